// File: rtl/bram_arb_pkg.sv
// Shared types and default sizes for the two-port BRAM arbiter.
package bram_arb_pkg;
  localparam int DEF_ADDR_W    = 3;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 4;

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} arb_state_e;
  typedef logic req_idx_t;
endpackage

// File: rtl/bram_arb_rr_pick.sv
// Two-way priority pick: the pointed-to requester wins if it asks, else the other one.
module bram_arb_rr_pick
  import bram_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_idx_t   prio_i,
  output logic [1:0] gnt_o
);
  always_comb begin
    gnt_o = '0;
    if (req_i[prio_i])       gnt_o[prio_i]  = 1'b1;
    else if (req_i[~prio_i]) gnt_o[~prio_i] = 1'b1;
  end
endmodule

// File: rtl/bram_port_arbiter.sv
// Two-requester BRAM port arbiter with lock/burst ownership and 1-cycle read return.
// BRAM_ARB_RR_EN defined: round-robin in IDLE; undefined: requester 0 fixed priority.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic              r0_lock,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic              r1_lock,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r0_gnt,
  output logic              r1_gnt,
  output logic              r0_rvalid,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ena,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  arb_state_e        state_q, state_d;
  req_idx_t          owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0] rdata_q;

  logic [1:0] req, lock, we, gnt, pick_gnt;
  logic       owner_hold, any_gnt;
  req_idx_t   win, pick_prio;

  assign req  = {r1_req, r0_req};
  assign lock = {r1_lock, r0_lock};
  assign we   = {r1_we, r0_we};

`ifdef BRAM_ARB_RR_EN
  req_idx_t prio_q;
  always_ff @(posedge clk) begin
    if (reset)        prio_q <= 1'b0;
    else if (any_gnt) prio_q <= ~win;
  end
  assign pick_prio = (state_q == OWNED) ? ~owner_q : prio_q;
`else
  assign pick_prio = (state_q == OWNED) ? ~owner_q : 1'b0;
`endif

  bram_arb_rr_pick u_pick (.req_i(req), .prio_i(pick_prio), .gnt_o(pick_gnt));

  // A locked owner under its burst cap bypasses the pick entirely.
  assign owner_hold = (state_q == OWNED) && req[owner_q] && lock[owner_q] && (cnt_q < MAX_CNT);

  always_comb begin
    gnt = '0;
    if (!reset) begin
      if (owner_hold) gnt[owner_q] = 1'b1;
      else            gnt = pick_gnt;
    end
  end

  assign any_gnt = |gnt;
  assign win     = gnt[1];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (owner_hold) begin
      cnt_d = cnt_q + 1'b1;
    end else if (any_gnt && lock[win]) begin
      state_d = OWNED;
      owner_d = win;
      cnt_d   = CNT_W'(1);
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  assign rd_vld_d = gnt & ~we;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      rd_vld_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      rd_vld_q <= rd_vld_d;
      rdata_q  <= rdata;
    end
  end

  assign r0_gnt = gnt[0];
  assign r1_gnt = gnt[1];
  assign mem_ena  = any_gnt;
  assign mem_wea  = any_gnt & we[win];
  assign mem_addr = gnt[1] ? r1_addr  : (gnt[0] ? r0_addr  : '0);
  assign mem_din  = gnt[1] ? r1_wdata : (gnt[0] ? r0_wdata : '0);

  // Masking with reset kills a read that was in flight when reset arrived.
  assign r0_rvalid = rd_vld_q[0] & ~reset;
  assign r1_rvalid = rd_vld_q[1] & ~reset;
  assign rdata = reset ? '0 : ((r0_rvalid | r1_rvalid) ? mem_dout : rdata_q);
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed self-checking bench for bram_port_arbiter (default parameters).
module tb_bram_port_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic       r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
  logic [2:0] r0_addr, r1_addr, mem_addr;
  logic [7:0] r0_wdata, r1_wdata, rdata, mem_din, mem_dout;
  logic       r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_ena, mem_wea;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  bram_port_arbiter dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
    .rdata(rdata), .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    r0_req = 0; r0_we = 0; r0_lock = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_we = 0; r1_lock = 0; r1_addr = 0; r1_wdata = 0;
  endtask

  logic exp0 [4];

  initial begin
    idle_inputs();
    mem_dout = 8'h00;
    reset = 1;
    r0_req = 1; r1_req = 1;
    tick(); tick();
    chk("rst_r0_gnt", r0_gnt, 0);
    chk("rst_r1_gnt", r1_gnt, 0);
    chk("rst_ena", mem_ena, 0);
    chk("rst_rvalid", {r1_rvalid, r0_rvalid}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_addr", mem_addr, 0);

    // Single read in the first cycle out of reset
    reset = 0;
    idle_inputs();
    r0_req = 1; r0_addr = 3;
    #1;
    chk("rd_gnt0", r0_gnt, 1);
    chk("rd_gnt1", r1_gnt, 0);
    chk("rd_ena", mem_ena, 1);
    chk("rd_wea", mem_wea, 0);
    chk("rd_addr", mem_addr, 3);
    tick();
    idle_inputs();
    mem_dout = 8'h0C;
    #1;
    chk("rd_rvalid0", r0_rvalid, 1);
    chk("rd_rvalid1", r1_rvalid, 0);
    chk("rd_rdata", rdata, 8'h0C);
    tick();
    mem_dout = 8'h55;
    #1;
    chk("hold_rvalid0", r0_rvalid, 0);
    chk("hold_rdata", rdata, 8'h0C);

    // Write from r1
    r1_req = 1; r1_we = 1; r1_addr = 7; r1_wdata = 8'h60;
    #1;
    chk("wr_gnt1", r1_gnt, 1);
    chk("wr_ena", mem_ena, 1);
    chk("wr_wea", mem_wea, 1);
    chk("wr_addr", mem_addr, 7);
    chk("wr_din", mem_din, 8'h60);
    tick();
    idle_inputs();
    #1;
    chk("wr_no_rvalid", {r1_rvalid, r0_rvalid}, 0);
    chk("wr_rdata_hold", rdata, 8'h0C);

    // Contention, no lock
`ifdef BRAM_ARB_RR_EN
    exp0[0] = 1; exp0[1] = 0; exp0[2] = 1; exp0[3] = 0;
`else
    exp0[0] = 1; exp0[1] = 1; exp0[2] = 1; exp0[3] = 1;
`endif
    for (int c = 0; c < 5; c++) begin
      idle_inputs();
      if (c < 4) begin
        r0_req = 1; r0_addr = 1; r1_req = 1; r1_addr = 2;
      end
      mem_dout = 8'hA0 + 8'(c);
      #1;
      if (c > 0) begin
        chk("cont_rvalid0", r0_rvalid, exp0[c-1]);
        chk("cont_rvalid1", r1_rvalid, !exp0[c-1]);
        chk("cont_rdata", rdata, 8'hA0 + 8'(c));
      end
      if (c < 4) begin
        chk("cont_gnt0", r0_gnt, exp0[c]);
        chk("cont_gnt1", r1_gnt, !exp0[c]);
      end
      tick();
    end

    // Burst cap: r0 locked, r1 waiting
    for (int c = 0; c < 5; c++) begin
      idle_inputs();
      r0_req = 1; r0_lock = 1; r0_we = 1; r0_addr = 4;
      r1_req = 1; r1_we = 1; r1_addr = 5;
      #1;
      chk("burst_gnt0", r0_gnt, (c < 4) ? 1 : 0);
      chk("burst_gnt1", r1_gnt, (c < 4) ? 0 : 1);
      tick();
    end
    idle_inputs();
    tick();

    // Address wrap: 7 then 0
    r0_req = 1; r0_addr = 7;
    #1;
    chk("wrap_gnt_a", r0_gnt, 1);
    chk("wrap_addr_a", mem_addr, 7);
    tick();
    r0_addr = 0; mem_dout = 8'h77;
    #1;
    chk("wrap_gnt_b", r0_gnt, 1);
    chk("wrap_addr_b", mem_addr, 0);
    chk("wrap_rv_a", r0_rvalid, 1);
    chk("wrap_rd_a", rdata, 8'h77);
    tick();
    idle_inputs();
    mem_dout = 8'h10;
    #1;
    chk("wrap_rv_b", r0_rvalid, 1);
    chk("wrap_rd_b", rdata, 8'h10);
    tick();

    // Reset with a read in flight
    r0_req = 1; r0_addr = 5;
    #1;
    chk("rstrd_gnt", r0_gnt, 1);
    tick();
    idle_inputs();
    reset = 1; mem_dout = 8'hEE;
    #1;
    chk("rstrd_rvalid", r0_rvalid, 0);
    chk("rstrd_rdata", rdata, 0);
    chk("rstrd_ena", mem_ena, 0);
    tick();
    reset = 0;
    r0_req = 1; r1_req = 1; r0_addr = 2; r1_addr = 6;
    #1;
    chk("post_rst_gnt0", r0_gnt, 1);
    chk("post_rst_gnt1", r1_gnt, 0);
    chk("post_rst_rvalid", {r1_rvalid, r0_rvalid}, 0);
    tick();
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
